iaoq_fetch_queue: RTL and testbench

IAOQ_FETCH_QUEUE -- requirements
Module: iaoq_fetch_queue

---
 rtl/iaoq_fetch_queue.sv | 91 +++++++++
 tb/tb_iaoq_fetch_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iaoq_fetch_queue.sv
// Instruction fetch queue: drives a sequential fetch PC into instruction memory,
// buffers fetched {inst, pc} pairs in a FIFO, and flushes and redirects on a taken branch.
module iaoq_fetch_queue #(
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INST_W-1:0]            imem_data,
    output logic                         fetch_en,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         inst_valid,
    output logic [INST_W-1:0]            inst,
    output logic [ADDR_W-1:0]            inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              push;
    logic              pop;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    // Occupancy decode, handshake and head presentation (head forced to 0 when empty)
    always_comb begin
        inst_valid = (cnt != '0);
        full       = (cnt == CNT_W'(DEPTH));
        pop        = inst_valid & ~stall & ~redirect;
        push       = ~redirect & (~full | pop);
        fetch_en   = push;
        imem_addr  = fetch_pc;
        count      = cnt;
        inst       = '0;
        inst_pc    = '0;
        if (inst_valid) begin
            inst    = inst_mem[rd_ptr];
            inst_pc = pc_mem[rd_ptr];
        end
    end

    // Control state; redirect flushes the queue and reloads the fetch PC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage is not reset; it is only observable through a valid head
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_iaoq_fetch_queue.sv
// Bench for iaoq_fetch_queue: directed vector table, a RESET_PC wrap instance,
// async reset probe, and randomized stall/redirect traffic against a queue model.
module tb_iaoq_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_data;
    logic        fetch_en, stall, redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid, full;
    logic [31:0] inst, inst_pc;
    logic [2:0]  count;

    logic [31:0] w_addr, w_data, w_inst, w_inst_pc;
    logic        w_fetch_en, w_valid, w_full;
    logic [2:0]  w_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    assign imem_data = mem_of(imem_addr);
    assign w_data    = mem_of(w_addr);

    iaoq_fetch_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .fetch_en(fetch_en), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .count(count), .full(full)
    );

    iaoq_fetch_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) u_wrap (
        .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_data(w_data),
        .fetch_en(w_fetch_en), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_inst_pc), .count(w_count), .full(w_full)
    );

    typedef struct {
        logic        s;
        logic        r;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] pc;
        int          cnt;
        logic        f;
        logic        fe;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    vec_t        tbl [15];
    ent_t        q [$];
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: pop from the front, then fetch into the back when room
    task automatic model_edge(input logic s, input logic r, input logic [31:0] rpc);
        bit p;
        if (r) begin
            q.delete();
            m_pc = rpc;
        end else begin
            p = (q.size() != 0) && !s;
            if (p) void'(q.pop_front());
            if (q.size() < DEPTH) begin
                q.push_back('{inst: mem_of(m_pc), pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        bit          v = (q.size() != 0);
        logic [31:0] ep = v ? q[0].pc : 32'h0;
        logic [31:0] ei = v ? q[0].inst : 32'h0;
        bit          p = v && !stall && !redirect;
        check("m_valid", 32'(inst_valid), 32'(v));
        check("m_inst_pc", inst_pc, ep);
        check("m_inst", inst, ei);
        check("m_count", 32'(count), 32'(q.size()));
        check("m_full", 32'(full), 32'(q.size() == DEPTH));
        check("m_fetch_en", 32'(fetch_en), 32'(!redirect && (q.size() < DEPTH || p)));
        check("m_imem_addr", imem_addr, m_pc);
    endtask

    // One cycle: drive, check at negedge, advance model at posedge
    task automatic step(input logic s, input logic r, input logic [31:0] rpc, input int row);
        logic [31:0] wpc;
        stall = s; redirect = r; redirect_pc = rpc;
        @(negedge clk);
        if (row < 0) begin
            check_model();
        end else begin
            check("t_valid", 32'(inst_valid), 32'(tbl[row].v));
            check("t_inst_pc", inst_pc, tbl[row].pc);
            check("t_inst", inst, tbl[row].v ? mem_of(tbl[row].pc) : 32'h0);
            check("t_count", 32'(count), 32'(tbl[row].cnt));
            check("t_full", 32'(full), 32'(tbl[row].f));
            check("t_fetch_en", 32'(fetch_en), 32'(tbl[row].fe));
            check("t_imem_addr", imem_addr, tbl[row].addr);
            if (row == 0) begin
                check("w_valid0", 32'(w_valid), 32'h0);
            end else begin
                wpc = 32'hFFFF_FFF8 + 32'(4 * (row - 1));
                check("w_valid", 32'(w_valid), 32'h1);
                check("w_inst_pc", w_inst_pc, wpc);
                check("w_inst", w_inst, mem_of(wpc));
            end
        end
        @(posedge clk);
        model_edge(s, r, rpc);
        #1;
    endtask

    initial begin
        //         s     r     rpc          v     pc        cnt f     fe    addr
        tbl[0]  = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   0, 1'b0, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,   1, 1'b0, 1'b1, 32'h4};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,   2, 1'b0, 1'b1, 32'h8};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,   3, 1'b0, 1'b1, 32'hC};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,   4, 1'b1, 1'b0, 32'h10};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,   4, 1'b1, 1'b0, 32'h10};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h0,   4, 1'b1, 1'b1, 32'h10};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h4,   4, 1'b1, 1'b0, 32'h14};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h4,   4, 1'b1, 1'b1, 32'h14};
        tbl[9]  = '{1'b0, 1'b1, 32'h40,    1'b1, 32'h8,   4, 1'b1, 1'b0, 32'h18};
        tbl[10] = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   0, 1'b0, 1'b1, 32'h40};
        tbl[11] = '{1'b0, 1'b1, 32'h80,    1'b1, 32'h40,  1, 1'b0, 1'b0, 32'h44};
        tbl[12] = '{1'b1, 1'b1, 32'h100,   1'b0, 32'h0,   0, 1'b0, 1'b0, 32'h80};
        tbl[13] = '{1'b1, 1'b0, 32'h0,     1'b0, 32'h0,   0, 1'b0, 1'b1, 32'h100};
        tbl[14] = '{1'b0, 1'b0, 32'h0,     1'b1, 32'h100, 1, 1'b0, 1'b1, 32'h104};

        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        q.delete(); m_pc = 32'h0;
        @(posedge clk);
        #2 reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].s, tbl[i].r, tbl[i].rpc, i);
        end

        // Redirect with three entries queued, then drain while fetching the target
        step(1'b1, 1'b1, 32'h0, -1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, -1);
        step(1'b0, 1'b1, 32'h40, -1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, -1);

        for (int i = 0; i < 500; i++) begin
            logic s, r;
            logic [31:0] rpc;
            if (((i / 40) % 2) == 1) s = ($urandom_range(0, 99) < 85);
            else                     s = ($urandom_range(0, 99) < 15);
            r   = ($urandom_range(0, 99) < 4);
            rpc = $urandom;
            if (i == 250) begin
                // Asynchronous reset between edges must act without a clock
                reset = 1'b0;
                #1;
                check("rst_valid", 32'(inst_valid), 32'h0);
                check("rst_count", 32'(count), 32'h0);
                check("rst_full", 32'(full), 32'h0);
                check("rst_inst", inst, 32'h0);
                check("rst_inst_pc", inst_pc, 32'h0);
                check("rst_imem_addr", imem_addr, 32'h0);
                #2 reset = 1'b1;
                q.delete(); m_pc = 32'h0;
            end
            step(s, r, rpc, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
